// File: rtl/fft_bitrev_reorder_if.sv
// Complex sample stream around the FFT output reorder buffer: bit-reversed in, natural order out.
// Both sides are valid-only (no backpressure); the reorder buffer never stalls its producer.
interface fft_bitrev_reorder_if #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_N     = 6
);
    logic                  di_en;
    logic [DATA_WIDTH-1:0] di_re;
    logic [DATA_WIDTH-1:0] di_im;
    logic                  do_en;
    logic [DATA_WIDTH-1:0] do_re;
    logic [DATA_WIDTH-1:0] do_im;
    logic [LOG2_N-1:0]     do_idx;
    logic                  do_sop;
    logic                  do_eop;

    modport master (
        output di_en, di_re, di_im,
        input  do_en, do_re, do_im, do_idx, do_sop, do_eop
    );

    modport slave (
        input  di_en, di_re, di_im,
        output do_en, do_re, do_im, do_idx, do_sop, do_eop
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Reorders bit-reversed FFT frames to natural order via ping-pong banks; output lags input by N+1 cycles.
// No backpressure: the writer is never stalled and each completed frame drains as one gapless N-cycle burst.
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 16,
    parameter int LOG2_N     = 6
) (
    input  logic                clk,
    input  logic                rstn,
    fft_bitrev_reorder_if.slave bus
);
    localparam int                N        = 1 << LOG2_N;
    localparam logic [LOG2_N-1:0] LAST_IDX = '1;

    typedef enum logic {S_IDLE, S_READ} state_t;

    state_t                    r_state;
    logic [LOG2_N-1:0]         r_wr_cnt;
    logic [LOG2_N-1:0]         r_rd_cnt;
    logic                      r_wr_bank;
    logic                      r_rd_bank;
    logic [2*DATA_WIDTH-1:0]   r_mem [2*N];
    logic                      r_do_en;
    logic                      r_do_sop;
    logic                      r_do_eop;
    logic [DATA_WIDTH-1:0]     r_do_re;
    logic [DATA_WIDTH-1:0]     r_do_im;
    logic [LOG2_N-1:0]         r_do_idx;

    logic                      w_wr_last;
    logic [LOG2_N-1:0]         w_wr_addr;
    logic [2*DATA_WIDTH-1:0]   w_rd_dat;

    function automatic logic [LOG2_N-1:0] bitrev(input logic [LOG2_N-1:0] v);
        logic [LOG2_N-1:0] r;
        for (int i = 0; i < LOG2_N; i++) begin
            r[i] = v[LOG2_N-1-i];
        end
        return r;
    endfunction

    assign w_wr_last = bus.di_en && (r_wr_cnt == LAST_IDX);
    assign w_wr_addr = bitrev(r_wr_cnt);
    assign w_rd_dat  = r_mem[{r_rd_bank, r_rd_cnt}];

    // Storage is deliberately unreset; the bank split is the top address bit.
    always_ff @(posedge clk) begin
        if (bus.di_en) begin
            r_mem[{r_wr_bank, w_wr_addr}] <= {bus.di_re, bus.di_im};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_do_en   <= 1'b0;
            r_do_sop  <= 1'b0;
            r_do_eop  <= 1'b0;
            r_do_re   <= '0;
            r_do_im   <= '0;
            r_do_idx  <= '0;
        end else begin
            r_do_en  <= 1'b0;
            r_do_sop <= 1'b0;
            r_do_eop <= 1'b0;

            if (bus.di_en) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
                if (w_wr_last) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end

            case (r_state)
                S_IDLE: begin
                    if (w_wr_last) begin
                        r_state   <= S_READ;
                        r_rd_cnt  <= '0;
                        r_rd_bank <= r_wr_bank;
                    end
                end
                S_READ: begin
                    r_do_en  <= 1'b1;
                    r_do_re  <= w_rd_dat[2*DATA_WIDTH-1:DATA_WIDTH];
                    r_do_im  <= w_rd_dat[DATA_WIDTH-1:0];
                    r_do_idx <= r_rd_cnt;
                    r_do_sop <= (r_rd_cnt == '0);
                    r_do_eop <= (r_rd_cnt == LAST_IDX);
                    // A frame finishing on the final read chains straight into the next bank.
                    if (w_wr_last) begin
                        r_rd_cnt  <= '0;
                        r_rd_bank <= r_wr_bank;
                    end else if (r_rd_cnt == LAST_IDX) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_rd_cnt <= r_rd_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.do_en  = r_do_en;
    assign bus.do_re  = r_do_re;
    assign bus.do_im  = r_do_im;
    assign bus.do_idx = r_do_idx;
    assign bus.do_sop = r_do_sop;
    assign bus.do_eop = r_do_eop;
endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for the reorder buffer: an N=8 instance for directed cases, an N=64 instance for random frames.
module tb_fft_bitrev_reorder;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_bitrev_reorder_if #(.DATA_WIDTH(16), .LOG2_N(3)) if3 ();
    fft_bitrev_reorder_if #(.DATA_WIDTH(16), .LOG2_N(6)) if6 ();

    fft_bitrev_reorder #(.DATA_WIDTH(16), .LOG2_N(3)) u_dut3 (.clk(clk), .rstn(rstn), .bus(if3));
    fft_bitrev_reorder #(.DATA_WIDTH(16), .LOG2_N(6)) u_dut6 (.clk(clk), .rstn(rstn), .bus(if6));

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
        logic [5:0]  idx;
    } exp_t;

    exp_t        q3[$];
    exp_t        q6[$];
    logic [15:0] fr3_re[8];
    logic [15:0] fr3_im[8];
    logic [15:0] fr6_re[64];
    logic [15:0] fr6_im[64];
    int          first_in3, last_in3, sop_cyc3;
    int          run3, max_run3, run6, max_run6;
    logic        prev_en3, prev_en6;
    logic [5:0]  prev_idx3, prev_idx6;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int brev(input int v, input int bits);
        int r = 0;
        for (int i = 0; i < bits; i++) begin
            if (v[i]) r |= 1 << (bits - 1 - i);
        end
        return r;
    endfunction

    // Scoreboard consumers: pop one expected sample per observed output beat.
    always @(negedge clk) begin
        if (!rstn) begin
            prev_en3 = 1'b0;
            run3 = 0;
        end else begin
            exp_t e;
            if (prev_en3 && prev_idx3 != 6'd7) chk("gap3", 32'(if3.do_en), 32'd1);
            if (if3.do_en) begin
                chk("q3_nonempty", 32'(q3.size() != 0), 32'd1);
                if (q3.size() != 0) begin
                    e = q3.pop_front();
                    chk("re3", 32'(if3.do_re), 32'(e.re));
                    chk("im3", 32'(if3.do_im), 32'(e.im));
                    chk("idx3", 32'(if3.do_idx), 32'(e.idx));
                    chk("sop3", 32'(if3.do_sop), 32'(e.idx == 6'd0));
                    chk("eop3", 32'(if3.do_eop), 32'(e.idx == 6'd7));
                end
                if (if3.do_sop) sop_cyc3 = cyc;
            end
            run3 = if3.do_en ? run3 + 1 : 0;
            if (run3 > max_run3) max_run3 = run3;
            prev_en3 = if3.do_en;
            prev_idx3 = 6'(if3.do_idx);
        end
    end

    always @(negedge clk) begin
        if (!rstn) begin
            prev_en6 = 1'b0;
            run6 = 0;
        end else begin
            exp_t e;
            if (prev_en6 && prev_idx6 != 6'd63) chk("gap6", 32'(if6.do_en), 32'd1);
            if (if6.do_en) begin
                chk("q6_nonempty", 32'(q6.size() != 0), 32'd1);
                if (q6.size() != 0) begin
                    e = q6.pop_front();
                    chk("re6", 32'(if6.do_re), 32'(e.re));
                    chk("im6", 32'(if6.do_im), 32'(e.im));
                    chk("idx6", 32'(if6.do_idx), 32'(e.idx));
                    chk("sop6", 32'(if6.do_sop), 32'(e.idx == 6'd0));
                    chk("eop6", 32'(if6.do_eop), 32'(e.idx == 6'd63));
                end
            end
            run6 = if6.do_en ? run6 + 1 : 0;
            if (run6 > max_run6) max_run6 = run6;
            prev_en6 = if6.do_en;
            prev_idx6 = if6.do_idx;
        end
    end

    // Drive natural-order frame fr3 in bit-reversed order; the full natural frame is expected once bin 7 goes in.
    task automatic send3(input bit gap, input int nsamp);
        for (int k = 0; k < nsamp; k++) begin
            @(negedge clk);
            if3.di_en = 1'b1;
            if3.di_re = fr3_re[brev(k, 3)];
            if3.di_im = fr3_im[brev(k, 3)];
            if (k == 0) first_in3 = cyc;
            last_in3 = cyc;
            if (k == 7) begin
                for (int j = 0; j < 8; j++) q3.push_back({fr3_re[j], fr3_im[j], 6'(j)});
            end
            if (gap) begin
                @(negedge clk);
                if3.di_en = 1'b0;
            end
        end
    endtask

    task automatic send6();
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if6.di_en = 1'b1;
            if6.di_re = fr6_re[brev(k, 6)];
            if6.di_im = fr6_im[brev(k, 6)];
            if (k == 63) begin
                for (int j = 0; j < 64; j++) q6.push_back({fr6_re[j], fr6_im[j], 6'(j)});
            end
        end
    endtask

    task automatic idle_all();
        @(negedge clk);
        if3.di_en = 1'b0;
        if6.di_en = 1'b0;
    endtask

    task automatic drain3(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((q3.size() != 0 || if3.do_en) && n < 300);
        chk(tag, 32'(q3.size()), 32'd0);
    endtask

    task automatic drain6(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((q6.size() != 0 || if6.do_en) && n < 600);
        chk(tag, 32'(q6.size()), 32'd0);
    endtask

    task automatic chk_zero3(input string tag);
        chk({tag, "_en"}, 32'(if3.do_en), 32'd0);
        chk({tag, "_re"}, 32'(if3.do_re), 32'd0);
        chk({tag, "_im"}, 32'(if3.do_im), 32'd0);
        chk({tag, "_idx"}, 32'(if3.do_idx), 32'd0);
        chk({tag, "_sop"}, 32'(if3.do_sop), 32'd0);
        chk({tag, "_eop"}, 32'(if3.do_eop), 32'd0);
    endtask

    initial begin
        if3.di_en = 1'b0; if3.di_re = '0; if3.di_im = '0;
        if6.di_en = 1'b0; if6.di_re = '0; if6.di_im = '0;
        max_run3 = 0; max_run6 = 0; sop_cyc3 = 0;
        prev_idx3 = '0; prev_idx6 = '0;
        repeat (3) @(negedge clk);
        chk_zero3("rst3");
        chk("rst6_en", 32'(if6.do_en), 32'd0);
        chk("rst6_re", 32'(if6.do_re), 32'd0);
        chk("rst6_idx", 32'(if6.do_idx), 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        // Single frame, continuous input: latency and reorder.
        for (int i = 0; i < 8; i++) begin fr3_re[i] = 16'(i); fr3_im[i] = 16'(i + 16); end
        max_run3 = 0;
        send3(1'b0, 8);
        idle_all();
        drain3("t1_drain");
        chk("t1_latency", 32'(sop_cyc3 - first_in3), 32'd9);
        chk("t1_burst", 32'(max_run3), 32'd8);

        // Three back-to-back frames must produce one 24-cycle burst.
        max_run3 = 0;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 8; i++) begin
                fr3_re[i] = 16'(i + 8 * f);
                fr3_im[i] = 16'(i + 8 * f + 100);
            end
            send3(1'b0, 8);
        end
        idle_all();
        drain3("t2_drain");
        chk("t2_burst", 32'(max_run3), 32'd24);

        // Half-rate input: burst starts 2 cycles after the last sample.
        max_run3 = 0;
        for (int i = 0; i < 8; i++) begin fr3_re[i] = 16'(i + 40); fr3_im[i] = 16'(i + 60); end
        send3(1'b1, 8);
        drain3("t3_drain");
        chk("t3_latency", 32'(sop_cyc3 - last_in3), 32'd2);
        chk("t3_burst", 32'(max_run3), 32'd8);

        // Full-scale values pass through bit-exact.
        for (int i = 0; i < 8; i++) begin fr3_re[i] = 16'h8000; fr3_im[i] = 16'h7FFF; end
        send3(1'b0, 8);
        idle_all();
        drain3("t5_drain");

        // Partial frame then reset: nothing emitted, next frame realigns to bin 0.
        for (int i = 0; i < 8; i++) begin fr3_re[i] = 16'(i + 200); fr3_im[i] = 16'(i + 220); end
        send3(1'b0, 5);
        idle_all();
        rstn = 1'b0;
        @(negedge clk);
        chk_zero3("t4_rst_a");
        @(negedge clk);
        chk_zero3("t4_rst_b");
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin fr3_re[i] = 16'(i + 300); fr3_im[i] = 16'(i + 320); end
        max_run3 = 0;
        send3(1'b0, 8);
        idle_all();
        drain3("t4_drain");
        chk("t4_burst", 32'(max_run3), 32'd8);

        // N=64: four continuous random frames, one 256-cycle burst.
        max_run6 = 0;
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 64; i++) begin
                fr6_re[i] = 16'($urandom);
                fr6_im[i] = 16'($urandom);
            end
            send6();
        end
        idle_all();
        drain6("t6_drain");
        chk("t6_burst", 32'(max_run6), 32'd256);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Streaming output reorder buffer on the result side of the R2SDF FFT core.
- Accepts FFT results in bit-reversed order on a valid-qualified complex stream (the core's do_en/do_re/do_im).
- Emits each N-point frame in natural order with index and frame markers.
- Ping-pong (two-bank) buffering sustains continuous back-to-back frames at one sample per clock.

Parameters:
- DATA_WIDTH, 16: width of each real/imag component; two's complement; passed through unmodified.
- LOG2_N, 6: log2 of FFT points; N = 2^LOG2_N; legal range 2..12.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  reset; asynchronous, active-low.
- di_en  input  1  input sample valid (driven by FFT do_en).
- di_re  input  DATA_WIDTH  input real part, bit-reversed order.
- di_im  input  DATA_WIDTH  input imaginary part, bit-reversed order.
- do_en  output  1  output sample valid.
- do_re  output  DATA_WIDTH  output real part, natural order.
- do_im  output  DATA_WIDTH  output imaginary part, natural order.
- do_idx  output  LOG2_N  natural frequency index of the current output sample.
- do_sop  output  1  high with do_en on index 0.
- do_eop  output  1  high with do_en on index N-1.

Behaviour:
- Reset: rstn is asynchronous and active-low; clk is the clock. All outputs go to 0. Write counter, read counter, write-bank select (bank 0) and read-active flag all clear. Memory contents are not reset.
- Frame alignment: the first accepted di_en sample after reset is bin 0 of a frame. There is no in-band frame marker.
- Storage: two banks of N x (2*DATA_WIDTH). Synchronous write; synchronous read with one-cycle latency.
- Write side:
  - Each cycle with di_en=1, write {di_re, di_im} to the current write bank at address bitrev(wr_cnt), then increment wr_cnt (mod N).
  - di_en=0 stalls the write side; gaps of any length are allowed.
  - When wr_cnt==N-1 is written, in the same cycle: toggle the write bank, set read-active, clear rd_cnt, and latch read bank = the just-filled bank.
- Read side (two states, IDLE and READ):
  - IDLE -> READ on frame completion.
  - In READ, issue address rd_cnt to the read bank each cycle and increment it.
  - READ -> IDLE after issuing address N-1, unless a new frame completes in that same cycle. In that case stay in READ, clear rd_cnt, and switch to the new bank. This gives a gapless continuation.
- Output stage, registered one cycle after the read is issued:
  - do_en=1.
  - do_re/do_im = stored data.
  - do_idx = issued address.
  - do_sop = (idx==0); do_eop = (idx==N-1).
  - When no read was issued, do_en=do_sop=do_eop=0; do_re/do_im/do_idx hold their last values.
- Latency: with continuous input, frame bin 0 written at cycle t0 gives do_en for idx 0 at t0+N+1. The output burst is always exactly N contiguous cycles.
- Throughput / overlap:
  - Input rate is at most 1 sample/cycle, so a new frame cannot complete before the prior read issues its final address.
  - Read and write never touch the same bank in the same cycle; no overflow condition exists.
- Reset mid-operation:
  - The partial input frame is discarded and any in-progress output burst is aborted immediately.
  - The next accepted sample after reset release is bin 0.

Test Plan:
- LOG2_N=3, continuous di_en. Feed di_re = [0,4,2,6,1,5,3,7] and di_im = di_re+16 -> do_re 0..7, do_im 16..23, do_idx 0..7. do_en starts 9 cycles after the first di_en. do_sop on idx 0, do_eop on idx 7.
- LOG2_N=3, three back-to-back frames of bit-reversed ramps with offsets 0, 8, 16 -> do_en high for 24 consecutive cycles, do_re 0..23 in order, do_sop/do_eop at 0/7, 8/15, 16/23.
- LOG2_N=3, di_en alternating 1,0 across one frame -> no output until the 8th sample is accepted. Then an 8-cycle contiguous natural-order burst starting 2 cycles after the last input sample.
- LOG2_N=3: 5 samples, then rstn low 2 cycles, then a full 8-sample frame -> all outputs 0 during reset, no burst from the partial frame, correct reorder of the following frame.
- Extreme values: di_re=0x8000, di_im=0x7FFF at every bin -> bit-exact passthrough, with no sign or width alteration.
- Default LOG2_N=6: 4 continuous frames of random signed data -> every output matches a bit-reverse golden model, and output bursts are gapless.
